control_sumador: RTL and testbench
==================================

CONTROL_SUMADOR -- requirements
Module: control_sumador

Interface
REQ-001 SHALL have parameter N, default 8, meaning the adder slice width in bits.
REQ-002 SHALL have parameter WORDS, default 4, meaning the slices per operand; operand width W = N*WORDS.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each, meaning the requester has an operation pending.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each, meaning the operation is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, W bits each, meaning the operands.
REQ-008 SHALL have ports req0_sub and req1_sub, input, 1 bit each; 1 selects a-b and 0 selects a+b.
REQ-009 SHALL have port res_valid, output, 1 bit, meaning the result is available.
REQ-010 SHALL have port res_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 SHALL have port res_data, output, W bits, meaning the sum or difference.
REQ-012 SHALL have port res_co, output, 1 bit, meaning the final carry-out; for subtraction 1 means no borrow.
REQ-013 SHALL have port res_id, output, 1 bit, meaning the requester that owns the result.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-015 In IDLE, SHALL grant one valid requester per cycle by asserting exactly one reqX_ready combinationally; ready SHALL be 0 in RUN and DONE.
REQ-016 Arbitration SHALL be round-robin: when both are valid, the requester not granted last wins; after reset req0 wins.
REQ-017 On handshake (valid & ready), SHALL capture a, the effective b (b, or ~b when sub=1), carry-in = sub, and the id, clear the word counter, and go to RUN.
REQ-018 In RUN, each cycle SHALL add word k (bits k*N+N-1 : k*N) of a and effective b plus the carry register, store the sum in result word k, load carry-out into the carry register, and increment k.
REQ-019 After word WORDS-1 is processed, SHALL go to DONE and latch the final carry into res_co.
REQ-020 Latency: for a handshake in cycle T, res_valid SHALL first assert in cycle T+WORDS+1.
REQ-021 In DONE, SHALL hold res_valid=1 with res_data, res_co and res_id stable until res_ready=1.
REQ-022 On res_valid & res_ready, SHALL return to IDLE in the next cycle and update the round-robin pointer.
REQ-023 SHALL accept no new request before the current result is consumed; throughput is one operation per WORDS+2 cycles or slower.
REQ-024 A requester deasserting valid in the cycle before a grant SHALL not be granted; captured operands SHALL not depend on later input changes.
REQ-025 Results SHALL be modulo 2^W, with no saturation.

Reset
REQ-026 While rst_n=0, regardless of state, SHALL force state IDLE, res_valid=0, res_data=0, res_co=0, res_id=0, carry=0, counter=0 and the RR pointer to favour req0.
REQ-027 A reset asserted during RUN or DONE SHALL discard the operation without producing a result.
REQ-028 req0_ready and req1_ready SHALL be 0 during reset.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/DONE) and the default N and WORDS constants in a package control_sumador_pkg.
REQ-030 SHALL use one instance of the existing N-bit ripple adder sumador_nb as the only arithmetic, shared across all words.
REQ-031 The word counter SHALL be $clog2(WORDS) bits wide, with a minimum of 1 bit.

Verification (N=8, WORDS=4)
REQ-032 Scenario 1: req0 adds 0x000000FF+0x00000001 -> res_data=0x00000100, co=0, id=0, res_valid 5 cycles after handshake.
REQ-033 Scenario 2: req1 adds 0xFFFFFFFF+0x00000001 -> res_data=0x00000000, co=1, id=1.
REQ-034 Scenario 3: sub 5-7 -> 0xFFFFFFFE with co=0; sub 7-5 -> 0x00000002 with co=1.
REQ-035 Scenario 4: both valid continuously from reset with res_ready=1 -> grants in the order req0, req1, req0, req1, and the ready pulses are never simultaneous.
REQ-036 Scenario 5: res_ready=0 for 10 cycles in DONE -> res_valid and data stay stable and both readies stay 0.
REQ-037 Scenario 6: rst_n pulsed low mid-RUN -> all outputs 0 immediately, no result produced, and the next grant goes to req0.

Source files
------------

// File: rtl/control_sumador_pkg.sv
// Shared types and default sizing for the word-serial adder/subtractor controller.
package control_sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF     = 8;
  localparam int WORDS_DEF = 4;

endpackage

// File: rtl/sumador_nb.sv
// N-bit ripple-carry adder; purely combinational.
module sumador_nb #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/control_sumador.sv
// Two-requester, word-serial add/subtract unit sharing one N-bit ripple adder.
//
//   state | meaning
//   IDLE  | arbitrate and accept one request
//   RUN   | add one N-bit word per cycle, carry held in a register
//   DONE  | present result until the consumer takes it
module control_sumador
  import control_sumador_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N*WORDS-1:0]   req0_a,
  input  logic [N*WORDS-1:0]   req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N*WORDS-1:0]   req1_a,
  input  logic [N*WORDS-1:0]   req1_b,
  input  logic                 req1_sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*WORDS-1:0]   res_data,
  output logic                 res_co,
  output logic                 res_id
);

  localparam int W  = N * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            carry_q, co_q, id_q;
  logic            rr_q;
  logic [CW-1:0]   cnt_q;
  logic            grant0, grant1, hs, last_word;
  logic [N-1:0]    a_w, b_w, s_w;
  logic            c_w;

  // rr_q=1 favours req1; gated by rst_n so no grant is visible during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && (!req1_valid || !rr_q)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
  end

  assign hs         = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign last_word  = (cnt_q == CW'(WORDS - 1));

  assign a_w = a_q[cnt_q*N +: N];
  assign b_w = b_q[cnt_q*N +: N];

  sumador_nb #(.N(N)) u_sumador (
    .a  (a_w),
    .b  (b_w),
    .ci (carry_q),
    .s  (s_w),
    .co (c_w)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs)        state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            // subtraction is a + ~b + 1, so the carry-in doubles as the sub flag
            if (grant1) begin
              a_q     <= req1_a;
              b_q     <= req1_sub ? ~req1_b : req1_b;
              carry_q <= req1_sub;
            end else begin
              a_q     <= req0_a;
              b_q     <= req0_sub ? ~req0_b : req0_b;
              carry_q <= req0_sub;
            end
            id_q  <= grant1;
            cnt_q <= '0;
          end
        end
        RUN: begin
          sum_q[cnt_q*N +: N] <= s_w;
          carry_q             <= c_w;
          cnt_q               <= cnt_q + 1'b1;
          if (last_word) co_q <= c_w;
        end
        DONE: begin
          if (res_ready) rr_q <= ~id_q;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = sum_q;
  assign res_co    = co_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_control_sumador.sv
// Directed bench for control_sumador (N=8, WORDS=4): arithmetic, latency, arbitration, stall and reset.
module tb_control_sumador;
  import control_sumador_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_co, res_id;
  logic [W-1:0] res_data;

  int n_checks = 0;
  int n_errors = 0;

  control_sumador #(.N(8), .WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_co     (res_co),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from a single requester; checks grant, latency and result.
  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sub, input logic [W-1:0] ed, input bit eco, input string tag);
    bit got;
    int lat;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    chk({tag, "_grant"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    req0_sub = ~sub; req1_sub = ~sub;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_data"}, res_data, ed);
    chk({tag, "_co"}, res_co, eco);
    chk({tag, "_id"}, res_id, id);
    if (res_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int  g[4];
    int  ng, both, bad;
    bit  done;
    logic [W-1:0] held;

    rst_n = 0; res_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_a = 32'd1; req0_b = 32'd2; req0_sub = 0;
    req1_a = 32'd10; req1_b = 32'd3; req1_sub = 1;
    #3;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_co", res_co, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // both requesters valid continuously from reset
    ng = 0; both = 0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both++;
      if (req0_ready)      begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
    end
    chk("rr_count", ng, 4);
    chk("rr_both", both, 0);
    chk("rr_g0", g[0], 0);
    chk("rr_g1", g[1], 1);
    chk("rr_g2", g[2], 0);
    chk("rr_g3", g[3], 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (res_valid) done = 1;
    end
    chk("rr_last_done", done, 1);
    chk("rr_last_data", res_data, 32'd7);
    chk("rr_last_id", res_id, 1);
    @(posedge clk); #1;

    run_op(0, 32'h000000FF, 32'h00000001, 0, 32'h00000100, 0, "add_ff_1");
    run_op(1, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, "add_wrap");
    run_op(0, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 0, "sub_5_7");
    run_op(1, 32'd7, 32'd5, 1, 32'h00000002, 1, "sub_7_5");

    // consumer stalls for 10 cycles
    res_ready = 0;
    run_op(1, 32'h12345678, 32'h11111111, 0, 32'h23456789, 0, "stall");
    held = res_data;
    req0_valid = 1; req1_valid = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== held || res_co !== 1'b0 || res_id !== 1'b1 ||
          req0_ready || req1_ready) bad++;
    end
    chk("stall_stable", bad, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    res_ready = 1;
    @(posedge clk); #1;

    // leaves the pointer favouring req1
    run_op(0, 32'd1, 32'd1, 0, 32'd2, 0, "pre_rst");

    // reset mid-RUN
    req0_valid = 1; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_sub = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req0_ready) done = 1;
    end
    chk("mid_grant", done, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_co", res_co, 0);
    chk("mid_rst_id", res_id, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) bad++;
    end
    chk("mid_no_result", bad, 0);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (res_valid) done = 1;
    end
    chk("post_rst_done", done, 1);
    chk("post_rst_data", res_data, 32'h33333333);
    chk("post_rst_id", res_id, 0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
